alu_cmd_driver: RTL and testbench

//  Initiator side of the 4-bit combinational ALU interface. Accepts operation commands over a

---
 rtl/alu_cmd_driver.sv | 160 ++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator for a combinational DATA_W-bit ALU.
// Takes commands over a valid/ready handshake and registers the operands and
// select onto the ALU ports. It samples the ALU result one cycle later and
// returns it with a zero flag over a second valid/ready handshake. It keeps an
// accumulator so chained ops can use the previous result as operand A.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_a, cmd_b, cmd_sel          command operands and ALU select
//   cmd_use_acc                    take operand A from the accumulator
//   acc_clr                        single-cycle accumulator clear pulse
//   alu_a, alu_b, alu_sel          registered ALU inputs
//   alu_c                          ALU result (combinational from alu_*)
//   res_valid/res_ready            result handshake
//   res_data, res_zero             captured result and its zero flag
//   acc                            accumulator value
//   op_count                       completed result handshakes, wrapping
module alu_cmd_driver #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [2:0]        cmd_sel,
    input  logic              cmd_use_acc,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic accept;
    logic res_hs;

    assign accept = (state_q == S_IDLE) && cmd_valid;
    assign res_hs = (state_q == S_RESP) && res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        acc_d       = acc_q;
        op_count_d  = op_count_q;

        // A clear arriving with the accept also zeroes an accumulator-sourced operand A.
        if (accept) begin
            if (cmd_use_acc) begin
                alu_a_d = acc_clr ? '0 : acc_q;
            end else begin
                alu_a_d = cmd_a;
            end
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_sel;
        end

        if (acc_clr) begin
            acc_d = '0;
        end

        // The result capture overrides a coincident clear.
        if (state_q == S_EXEC) begin
            res_data_d  = alu_c;
            res_zero_d  = (alu_c == '0);
            acc_d       = alu_c;
            res_valid_d = 1'b1;
        end

        if (res_hs) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            acc_q       <= acc_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign acc       = acc_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Testbench for alu_cmd_driver: a behavioural ALU plus a transaction-level
// reference model (expected operand, result, accumulator and counter).
module tb_alu_cmd_driver;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [2:0]        cmd_sel;
    logic              cmd_use_acc;
    logic              acc_clr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_c;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  op_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_acc = 0;
    int m_cnt = 0;

    alu_cmd_driver #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_sel     (cmd_sel),
        .cmd_use_acc (cmd_use_acc),
        .acc_clr     (acc_clr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_c       (alu_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .acc         (acc),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU: integer arithmetic reduced modulo 16
    function automatic int alu_ref(input int a, input int b, input int sel);
        case (sel)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return (~a) & 15;
            4: return a;
            5: return b;
            6: return (a + b) % 16;
            default: return (a - b + 16) % 16;
        endcase
    endfunction

    // The ALU attached to the driver
    always_comb alu_c = DATA_W'(alu_ref(int'(alu_a), int'(alu_b), int'(alu_sel)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_acc"},       32'(acc),       32'd0);
        chk({tag, "_op_count"},  32'(op_count),  32'd0);
        chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
        chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
        chk({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
    endtask

    // One full command/result transaction, entered and left at a negedge in IDLE.
    task automatic do_op(input int a, input int b, input int sel, input bit use_acc,
                         input bit clr_acc_accept, input bit clr_exec, input int stall,
                         input bit bp_cmd, input bit clr_resp);
        int exp_a;
        int exp_r;
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_a       = DATA_W'(a);
        cmd_b       = DATA_W'(b);
        cmd_sel     = 3'(sel);
        cmd_use_acc = use_acc;
        acc_clr     = clr_acc_accept;
        exp_a = use_acc ? (clr_acc_accept ? 0 : m_acc) : a;
        @(posedge clk);
        if (clr_acc_accept) m_acc = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        acc_clr   = clr_exec;
        chk("exec_alu_a",     32'(alu_a),     32'(exp_a));
        chk("exec_alu_b",     32'(alu_b),     32'(b));
        chk("exec_alu_sel",   32'(alu_sel),   32'(sel));
        chk("exec_ready",     32'(cmd_ready), 32'd0);
        chk("exec_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        exp_r = alu_ref(exp_a, b, sel);
        m_acc = exp_r;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("resp_valid", 32'(res_valid), 32'd1);
        chk("resp_data",  32'(res_data),  32'(exp_r));
        chk("resp_zero",  32'(res_zero),  32'(exp_r == 0));
        chk("resp_acc",   32'(acc),       32'(m_acc));
        for (int i = 0; i < stall; i++) begin
            res_ready = 1'b0;
            cmd_valid = bp_cmd;
            if (bp_cmd) begin
                cmd_a       = DATA_W'($urandom);
                cmd_b       = DATA_W'($urandom);
                cmd_sel     = 3'($urandom);
                cmd_use_acc = 1'($urandom);
            end
            acc_clr = clr_resp && (i == 0);
            @(posedge clk);
            if (clr_resp && (i == 0)) m_acc = 0;
            @(negedge clk);
            acc_clr = 1'b0;
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data",  32'(res_data),  32'(exp_r));
            chk("bp_zero",  32'(res_zero),  32'(exp_r == 0));
            chk("bp_ready", 32'(cmd_ready), 32'd0);
            chk("bp_alu_a", 32'(alu_a),     32'(exp_a));
            chk("bp_acc",   32'(acc),       32'(m_acc));
        end
        res_ready = 1'b1;
        @(posedge clk);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        @(negedge clk);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("hs_valid", 32'(res_valid), 32'd0);
        chk("hs_count", 32'(op_count),  32'(m_cnt));
        chk("hs_ready", 32'(cmd_ready), 32'd1);
        chk("hs_alu_a", 32'(alu_a),     32'(exp_a));
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
        cmd_use_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle_reset("reset");
        chk("reset_res_data", 32'(res_data), 32'd0);
        chk("reset_res_zero", 32'(res_zero), 32'd0);

        // Basic add 3+5 = 8
        do_op(3, 5, 6, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("add_acc", 32'(acc), 32'd8);
        // Chain: acc+9 wraps to 1, then acc-1 = 0
        do_op(0, 9, 6, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("chain_acc", 32'(acc), 32'd1);
        do_op(0, 1, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("chain_zero", 32'(res_zero), 32'd1);
        // Backpressure with a pending command; 4th handshake wraps op_count
        do_op(10, 4, 2, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        chk("wrap_count", 32'(op_count), 32'd0);
        // Load acc=7, then clear coinciding with an accumulator-sourced accept
        do_op(7, 0, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("acc7", 32'(acc), 32'd7);
        do_op(0, 2, 6, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("clr_acc_result", 32'(res_data), 32'd2);
        // Clear on the capture edge loses to the capture; clear in RESP wins
        do_op(5, 6, 6, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
        do_op(1, 1, 6, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1);

        // Reset during EXEC
        cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd3; cmd_sel = 3'd6; cmd_use_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        chk_idle_reset("midrst");
        @(posedge clk);
        @(negedge clk);
        chk("midrst_no_result", 32'(res_valid), 32'd0);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
